// File: rtl/dec_scan_seq.sv
// dec_scan_seq: round-robin select/enable sequencer feeding a 2-to-4 enable decoder.
// Each masked-in index is shown for DWELL cycles, then blanked for BLANK cycles.
module dec_scan_seq #(
    parameter int unsigned DWELL = 1000,
    parameter int unsigned BLANK = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [3:0] mask,
    output logic [1:0] sel,
    output logic       en,
    output logic       frame_done
);

    localparam int unsigned SEL_W = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHOW  = 2'd1,
        S_BLANK = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [SEL_W-1:0]   first_idx;
    logic [SEL_W-1:0]   next_idx;
    logic               next_wrap;

    // Lowest set bit of mask, used when starting from IDLE.
    always_comb begin
        first_idx = '0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) begin
                first_idx = SEL_W'(i);
            end
        end
    end

    // Next set mask bit searched circularly from sel+1 through sel itself.
    always_comb begin
        logic       found;
        logic [SEL_W-1:0] cand;
        found    = 1'b0;
        cand     = '0;
        next_idx = sel;
        for (int k = 1; k <= 4; k++) begin
            cand = sel + SEL_W'(k);
            if (!found && mask[cand]) begin
                found    = 1'b1;
                next_idx = cand;
            end
        end
        next_wrap = (next_idx <= sel);
    end

    // Sequencer FSM with registered sel/en/frame_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sel        <= '0;
            en         <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    en  <= 1'b0;
                    cnt <= '0;
                    if (run && (mask != 4'b0000)) begin
                        sel   <= first_idx;
                        state <= S_SHOW;
                        en    <= 1'b1;
                    end
                end
                S_SHOW: begin
                    if (!run) begin
                        state <= S_IDLE;
                        en    <= 1'b0;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(DWELL - 1)) begin
                        state <= S_BLANK;
                        en    <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_BLANK: begin
                    if (!run) begin
                        state <= S_IDLE;
                        en    <= 1'b0;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(BLANK - 1)) begin
                        cnt <= '0;
                        if (mask != 4'b0000) begin
                            sel        <= next_idx;
                            state      <= S_SHOW;
                            en         <= 1'b1;
                            frame_done <= next_wrap;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    en    <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_scan_seq.sv
// Bench for dec_scan_seq: directed scenarios plus random run/mask traffic,
// compared every cycle against a period-position reference model.
module tb_dec_scan_seq;

    localparam int unsigned DWELL  = 4;
    localparam int unsigned BLANK  = 2;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned PERIOD = DWELL + BLANK;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [3:0] mask;
    logic [1:0] sel;
    logic       en;
    logic       frame_done;

    int errors = 0;
    int checks = 0;

    // reference model: active flag, current index, position within the index period
    bit m_act;
    int m_idx;
    int m_t;
    bit m_fd;

    int fd_cnt;
    int bad_en_cnt;

    dec_scan_seq #(.DWELL(DWELL), .BLANK(BLANK), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .mask       (mask),
        .sel        (sel),
        .en         (en),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_act = 1'b0;
        m_idx = 0;
        m_t   = 0;
        m_fd  = 1'b0;
    endfunction

    function automatic void model_edge();
        int nxt;
        m_fd = 1'b0;
        if (!m_act) begin
            if (run && mask != 4'b0000) begin
                for (int i = 3; i >= 0; i--) if (mask[i]) m_idx = i;
                m_act = 1'b1;
                m_t   = 0;
            end
        end else if (!run) begin
            m_act = 1'b0;
        end else if (m_t == int'(PERIOD) - 1) begin
            nxt = -1;
            for (int k = 1; k <= 4; k++) begin
                if (nxt < 0 && mask[(m_idx + k) % 4]) nxt = (m_idx + k) % 4;
            end
            if (nxt < 0) begin
                m_act = 1'b0;
            end else begin
                m_fd  = (nxt <= m_idx);
                m_idx = nxt;
                m_t   = 0;
            end
        end else begin
            m_t++;
        end
    endfunction

    // One clock: advance model at the edge, compare on the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        @(negedge clk);
        chk("sel", 32'(sel), 32'(m_idx));
        chk("en", 32'(en), 32'(m_act && m_t < int'(DWELL)));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        if (frame_done) fd_cnt++;
        if (en && (sel == 2'd0 || sel == 2'd2)) bad_en_cnt++;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        run   = 1'b1;
        mask  = 4'hF;
        #1;
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_en", 32'(en), 32'd0);
        cycles(3);
        @(negedge clk);
        rst_n = 1'b1;

        // start edge: en rises one edge after release
        cycle();
        chk("start_en", 32'(en), 32'd1);
        cycles(7);
        chk("mid_show_sel", 32'(sel), 32'd1);

        // asynchronous reset pulse mid-SHOW of index 1
        #2 rst_n = 1'b0;
        #1;
        chk("async_sel", 32'(sel), 32'd0);
        chk("async_en", 32'(en), 32'd0);
        chk("async_fd", 32'(frame_done), 32'd0);
        #1 rst_n = 1'b1;
        model_reset();

        // full scan: two wraps in 48 cycles
        cycle();
        fd_cnt = 0;
        cycles(48);
        chk("full_fd_count", 32'(fd_cnt), 32'd2);

        // sparse mask 1010
        run = 1'b0;
        cycle();
        mask = 4'b1010;
        run  = 1'b1;
        cycle();
        fd_cnt = 0;
        bad_en_cnt = 0;
        cycles(24);
        chk("sparse_fd_count", 32'(fd_cnt), 32'd2);
        chk("sparse_no_0_2", 32'(bad_en_cnt), 32'd0);

        // single index 0100
        run = 1'b0;
        cycle();
        mask = 4'b0100;
        run  = 1'b1;
        fd_cnt = 0;
        cycle();
        chk("single_no_start_fd", 32'(fd_cnt), 32'd0);
        cycles(24);
        chk("single_fd_count", 32'(fd_cnt), 32'd4);

        // run dropped in 3rd SHOW cycle of index 1, then restart at 0
        run = 1'b0;
        cycle();
        mask = 4'hF;
        run  = 1'b1;
        cycle();
        cycles(8);
        run = 1'b0;
        cycle();
        chk("drop_sel", 32'(sel), 32'd1);
        chk("drop_en", 32'(en), 32'd0);
        run = 1'b1;
        cycle();
        chk("restart_sel", 32'(sel), 32'd0);

        // mask cleared during BLANK: back to IDLE
        cycles(4);
        mask = 4'b0000;
        cycles(4);
        chk("mask0_en", 32'(en), 32'd0);

        // run=0 on final BLANK cycle of index 3: no frame_done
        mask = 4'hF;
        cycle();
        cycles(23);
        chk("simul_sel", 32'(sel), 32'd3);
        run = 1'b0;
        cycle();
        chk("simul_fd", 32'(frame_done), 32'd0);
        chk("simul_en", 32'(en), 32'd0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            run = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 9) == 0) mask = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
